// File: rtl/beep_driver.sv
// -----------------------------------------------------------------------------
// beep_driver
//
// Purpose:
//    Plays a burst of 1..15 beeps on a piezo buzzer for each accepted request.
//    Each beep is an ON phase of ON_CYCLES clocks with a square-wave tone of
//    half-period TONE_DIV. Consecutive beeps are separated by a silent OFF
//    phase of OFF_CYCLES clocks. There is no OFF gap after the last beep. A
//    one-cycle done pulse marks the end of the burst.
//
// Parameters:
//    TONE_DIV    tone half-period in clk cycles        (2..65535)
//    ON_CYCLES   length of one beep in clk cycles      (2..2^24-1)
//    OFF_CYCLES  silent gap between beeps in clk cycles (2..2^24-1)
//
// Ports:
//    clk            system clock, rising edge
//    reset          asynchronous, active-high reset
//    req_i          beep request, one-cycle pulse
//    count_i        number of beeps, sampled when req_i is accepted
//    abort_i        (BEEP_ABORT_EN only) cancels a running burst
//    buzzer_o       square-wave drive to the piezo
//    beep_active_o  high on every ON-phase cycle (LED mirror)
//    busy_o         high in the ON and OFF states
//    done_o         one-cycle pulse when a burst ends
//
// Configuration:
//    BEEP_ABORT_EN  when defined, adds abort_i. Asserting abort_i during ON or
//                   OFF returns the block to IDLE on the next cycle and
//                   produces a done pulse. The default build has no abort
//                   port and always runs a burst to completion.
// -----------------------------------------------------------------------------
module beep_driver #(
   parameter int unsigned TONE_DIV   = 25000,
   parameter int unsigned ON_CYCLES  = 10000000,
   parameter int unsigned OFF_CYCLES = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_i,
   input  logic [3:0] count_i,
`ifdef BEEP_ABORT_EN
   input  logic       abort_i,
`endif
   output logic       buzzer_o,
   output logic       beep_active_o,
   output logic       busy_o,
   output logic       done_o
);

   // Terminal values of the phase and tone counters. Counters run from 0 up to
   // these values, so a phase of N cycles ends when the counter reads N-1.
   localparam logic [23:0] ON_LAST   = 24'(ON_CYCLES - 1);
   localparam logic [23:0] OFF_LAST  = 24'(OFF_CYCLES - 1);
   localparam logic [15:0] TONE_LAST = 16'(TONE_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] phaseCnt_q, phaseCnt_d;
   logic [15:0] toneCnt_q, toneCnt_d;
   logic [3:0]  remaining_q, remaining_d;
   logic        buzzer_q, buzzer_d;
   logic        beepActive_q, beepActive_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Next-state and next-output logic. All outputs are computed here for the
   // cycle after the edge and held in flops, so every output is glitch-free
   // and describes the state the FSM is entering. done defaults to 0 so it is
   // a single-cycle pulse. A request in IDLE is accepted even in the done
   // cycle, which allows back-to-back bursts with no dead cycle.
   always_comb begin
      state_d      = state_q;
      phaseCnt_d   = phaseCnt_q;
      toneCnt_d    = toneCnt_q;
      remaining_d  = remaining_q;
      buzzer_d     = buzzer_q;
      beepActive_d = beepActive_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_i && (count_i != 4'd0)) begin
               state_d      = ON;
               phaseCnt_d   = 24'd0;
               toneCnt_d    = 16'd0;
               remaining_d  = count_i;
               buzzer_d     = 1'b0;
               beepActive_d = 1'b1;
               busy_d       = 1'b1;
            end
         end

         ON: begin
            if (phaseCnt_q == ON_LAST) begin
               phaseCnt_d   = 24'd0;
               toneCnt_d    = 16'd0;
               buzzer_d     = 1'b0;
               beepActive_d = 1'b0;
               if (remaining_q > 4'd1) begin
                  state_d     = OFF;
                  remaining_d = remaining_q - 4'd1;
                  busy_d      = 1'b1;
               end else begin
                  state_d     = IDLE;
                  remaining_d = 4'd0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end
            end else begin
               phaseCnt_d = phaseCnt_q + 24'd1;
               if (toneCnt_q == TONE_LAST) begin
                  toneCnt_d = 16'd0;
                  buzzer_d  = ~buzzer_q;
               end else begin
                  toneCnt_d = toneCnt_q + 16'd1;
               end
            end
         end

         OFF: begin
            if (phaseCnt_q == OFF_LAST) begin
               state_d      = ON;
               phaseCnt_d   = 24'd0;
               toneCnt_d    = 16'd0;
               buzzer_d     = 1'b0;
               beepActive_d = 1'b1;
            end else begin
               phaseCnt_d = phaseCnt_q + 24'd1;
            end
         end

         default: begin
            state_d      = IDLE;
            phaseCnt_d   = 24'd0;
            toneCnt_d    = 16'd0;
            remaining_d  = 4'd0;
            buzzer_d     = 1'b0;
            beepActive_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase

`ifdef BEEP_ABORT_EN
      // Abort overrides everything above, including a request in the same
      // cycle. It only has an effect while a burst is running.
      if (abort_i && (state_q != IDLE)) begin
         state_d      = IDLE;
         phaseCnt_d   = 24'd0;
         toneCnt_d    = 16'd0;
         remaining_d  = 4'd0;
         buzzer_d     = 1'b0;
         beepActive_d = 1'b0;
         busy_d       = 1'b0;
         done_d       = 1'b1;
      end
`endif
   end

   // State and output registers. Reset clears everything immediately. It does
   // not produce a done pulse, so an interrupted burst ends silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         phaseCnt_q   <= 24'd0;
         toneCnt_q    <= 16'd0;
         remaining_q  <= 4'd0;
         buzzer_q     <= 1'b0;
         beepActive_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phaseCnt_q   <= phaseCnt_d;
         toneCnt_q    <= toneCnt_d;
         remaining_q  <= remaining_d;
         buzzer_q     <= buzzer_d;
         beepActive_q <= beepActive_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign buzzer_o      = buzzer_q;
   assign beep_active_o = beepActive_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_beep_driver.sv
// -----------------------------------------------------------------------------
// tb_beep_driver
//
// Purpose:
//    Scoreboard bench for beep_driver with TONE_DIV=2, ON_CYCLES=8 and
//    OFF_CYCLES=4. Every cycle the stimulus side pushes the expected
//    {busy, beep_active, buzzer, done} for that cycle into a queue. A separate
//    monitor pops the queue on each falling edge and compares.
//    Abort scenarios are included when BEEP_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_beep_driver;

   localparam int TD  = 2;
   localparam int ONC = 8;
   localparam int OFC = 4;

   logic       clk;
   logic       reset;
   logic       req;
   logic [3:0] count;
   logic       abort;
   logic       buzzer;
   logic       beepActive;
   logic       busy;
   logic       done;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] expQ[$];
   int         cycQ[$];

   // Scoreboard model state. The stimulus side owns these variables.
   int  cyc         = 0;
   int  seqStart    = 0;
   int  seqCount    = 0;
   bit  seqActive   = 1'b0;
   bit  pendingDone = 1'b0;

   beep_driver #(
      .TONE_DIV   (TD),
      .ON_CYCLES  (ONC),
      .OFF_CYCLES (OFC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_i         (req),
      .count_i       (count),
`ifdef BEEP_ABORT_EN
      .abort_i       (abort),
`endif
      .buzzer_o      (buzzer),
      .beep_active_o (beepActive),
      .busy_o        (busy),
      .done_o        (done)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {busy, beep_active, buzzer, done} at cycle t after the cycle in
   // which a burst of n beeps was accepted. The burst occupies cycles
   // 1..n*ON+(n-1)*OFF and is followed by done on the next cycle.
   function automatic logic [3:0] model(input int t, input int n);
      int total;
      int off;
      total = n * ONC + (n - 1) * OFC;
      if (t == total + 1) return 4'b0001;
      if ((t < 1) || (t > total)) return 4'b0000;
      off = (t - 1) % (ONC + OFC);
      if (off < ONC) return {1'b1, 1'b1, ((off / TD) % 2) == 1, 1'b0};
      return 4'b1000;
   endfunction

   // Drive one cycle of inputs and push the expected outputs for that cycle.
   // accept says whether this request is expected to start a new burst.
   task automatic applyStimulus(input logic r, input logic [3:0] c,
                                input logic rst, input logic ab,
                                input bit accept);
      logic [3:0] e;
      @(posedge clk);
      #1;
      reset = rst;
      req   = r;
      count = c;
      abort = ab;
      cyc++;
      if (rst) begin
         e           = 4'b0000;
         seqActive   = 1'b0;
         pendingDone = 1'b0;
      end else if (pendingDone) begin
         e           = 4'b0001;
         pendingDone = 1'b0;
      end else if (seqActive) begin
         e = model(cyc - seqStart, seqCount);
      end else begin
         e = 4'b0000;
      end
      expQ.push_back(e);
      cycQ.push_back(cyc);
      if (!rst && ab && seqActive) begin
         seqActive   = 1'b0;
         pendingDone = 1'b1;
      end
      if (accept) begin
         seqActive = 1'b1;
         seqStart  = cyc;
         seqCount  = int'(c);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input logic [3:0] e, input int c);
      logic [3:0] act;
      act = {busy, beepActive, buzzer, done};
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("[TB] FAIL outputs@cycle%0d busy/active/buzzer/done got %b want %b",
                  c, act, e);
      end
   endtask

   // Monitor: on each falling edge, compare against the oldest expectation.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front(), cycQ.pop_front());
      end
   end

   // Directed scenarios. Comments give the cycle numbering relative to the
   // request cycle (cycle 0).
   initial begin
      reset = 1'b0;
      req   = 1'b0;
      count = 4'd0;
      abort = 1'b0;

      $display("[TB] reset state");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(2);

      $display("[TB] single beep, count=1");
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      idle(12);

      $display("[TB] three beeps, count=3");
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      idle(35);

      $display("[TB] count=2 with ignored request at cycle 5");
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      idle(4);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      idle(18);

      $display("[TB] count=0 request ignored");
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      idle(4);

      $display("[TB] back-to-back request in done cycle");
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      idle(8);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      idle(11);

      $display("[TB] reset at cycle 10 of count=3");
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      idle(9);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(3);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      idle(11);

`ifdef BEEP_ABORT_EN
      $display("[TB] abort at cycle 11 of count=3");
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      idle(10);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      idle(5);
`endif

      // Let the monitor drain the queue, with a bounded wait.
      for (int i = 0; (i < 4) && (expQ.size() > 0); i++) @(posedge clk);
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard drain: %0d expectations left, want 0",
                  expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
